// File: rtl/spi_regfile.sv
// spi_regfile: SPI mode-0 register bank with write and read-back frames, oversampled on clk
module spi_regfile #(
  parameter int NUM_REGS = 5,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       COPI,
  input  logic                       nCS,
  output logic                       CIPO,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe,
  output logic                       frame_err
);
  localparam int SH_W = ADDR_W > DATA_W ? ADDR_W : DATA_W;
  localparam int CNT_W = $clog2(SH_W + 1) + 1;
  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sclk_q, copi_q, ncs_q, ready_q;
  logic sclk_d, ncs_d, sclk_s, copi_s, ncs_s, ready;
  logic rise, fall, ncs_rise, shift, cmd_end, data_end, abort, commit, err, rw, bad;
  logic [CNT_W-1:0] cnt;
  logic [SH_W-1:0] sh;
  logic [ADDR_W:0] cmd_w;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] sout, rd_val;
  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign copi_s = copi_q[SYNC_STAGES-1];
  assign ncs_s = ncs_q[SYNC_STAGES-1];
  // ready rises once the nCS chain holds real pin samples, so reset values never look like a deselect
  assign ready = ready_q[SYNC_STAGES-1];
  assign rise = sclk_s && !sclk_d;
  assign fall = !sclk_s && sclk_d;
  assign ncs_rise = ncs_s && !ncs_d;
  assign cmd_w = {sh[ADDR_W-1:0], copi_s};
  assign shift = rise && !ncs_rise && (state == CMD || state == DATA);
  assign cmd_end = shift && state == CMD && cnt == CNT_W'(ADDR_W);
  assign data_end = shift && state == DATA && cnt == CNT_W'(DATA_W - 1);
  assign abort = ncs_rise && (state == CMD || state == DATA);
  assign commit = ncs_rise && state == DONE && rw && !bad;
  assign err = abort || (ncs_rise && state == DONE && bad);
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (cmd_w[ADDR_W-1:0] == ADDR_W'(i)) rd_val = regs_flat[i*DATA_W +: DATA_W];
  end
  always_comb begin
    nxt = state;
    if (abort) nxt = DONE;
    else if (state == DONE) nxt = ncs_s && ready ? IDLE : DONE;
    else if (state == IDLE) nxt = ncs_s ? IDLE : CMD;
    else if (cmd_end) nxt = DATA;
    else if (data_end) nxt = DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= DONE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sclk_q <= '0;
      copi_q <= '0;
      ncs_q <= '1;
      ready_q <= '0;
      sclk_d <= 1'b0;
      ncs_d <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
      copi_q <= {copi_q[SYNC_STAGES-2:0], COPI};
      ncs_q <= {ncs_q[SYNC_STAGES-2:0], nCS};
      ready_q <= {ready_q[SYNC_STAGES-2:0], 1'b1};
      sclk_d <= sclk_s;
      ncs_d <= ncs_s;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      sh <= '0;
      rw <= 1'b0;
      bad <= 1'b0;
      addr <= '0;
      sout <= '0;
      CIPO <= 1'b0;
      cipo_oe <= 1'b0;
      wr_strobe <= '0;
      frame_err <= 1'b0;
      regs_flat <= {NUM_REGS{RESET_VAL}};
    end else begin
      cnt <= state == IDLE || cmd_end || data_end ? '0 : shift ? cnt + CNT_W'(1) : cnt;
      if (shift) sh <= (sh << 1) | SH_W'(copi_s);
      if (cmd_end) begin
        rw <= cmd_w[ADDR_W];
        addr <= cmd_w[ADDR_W-1:0];
        bad <= int'(cmd_w[ADDR_W-1:0]) >= NUM_REGS;
        sout <= rd_val;
        cipo_oe <= !cmd_w[ADDR_W];
      end else if (ncs_rise) cipo_oe <= 1'b0;
      if (ncs_rise) CIPO <= 1'b0;
      else if (fall && state == DATA && cipo_oe) begin
        CIPO <= sout[DATA_W-1];
        sout <= sout << 1;
      end
      frame_err <= err;
      for (int i = 0; i < NUM_REGS; i++) begin
        wr_strobe[i] <= commit && addr == ADDR_W'(i);
        if (commit && addr == ADDR_W'(i)) regs_flat[i*DATA_W +: DATA_W] <= sh[DATA_W-1:0];
      end
    end
endmodule
